// File: rtl/pci_rr_arbiter_if.sv
// ============================================================================
// pci_rr_arbiter_if : REQ#/GNT# and bus-activity signals of the central arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface pci_rr_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] req;
  logic                   frame_n;
  logic                   irdy_n;
  logic [NUM_MASTERS-1:0] gnt;
  logic [IDX_W-1:0]       owner;
  logic                   owner_vld;

  // slave = arbiter side, master = bus/initiator side
  modport slave (
    input  req, frame_n, irdy_n,
    output gnt, owner, owner_vld
  );

  modport master (
    output req, frame_n, irdy_n,
    input  gnt, owner, owner_vld
  );
endinterface

`default_nettype wire

// File: rtl/pci_rr_arbiter.sv
// ============================================================================
// pci_rr_arbiter : round-robin PCI central arbiter; ARB_PARK_EN enables parking
// Rev 1.0
// ============================================================================
`default_nettype none

module pci_rr_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS),
  parameter int TIMEOUT     = 16,
  parameter int PARK_MASTER = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pci_rr_arbiter_if.slave bus
);

  localparam int CNT_W = 8;
`ifdef ARB_PARK_EN
  localparam bit PARK_ON = 1'b1;
`else
  localparam bit PARK_ON = 1'b0;
`endif
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_nx;
  logic [IDX_W-1:0]       owner_q, owner_nx;
  logic                   vld_q, vld_nx;
  logic [IDX_W-1:0]       last, last_nx;
  logic                   started, started_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;

  logic                   busy;
  logic                   others_req;
  logic                   release_now;
  logic                   cand_found;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       probe;

  function automatic logic [NUM_MASTERS-1:0] gnt_for(input logic [IDX_W-1:0] idx);
    return ~(NUM_MASTERS'(1) << idx);
  endfunction

  assign busy       = ~bus.frame_n | ~bus.irdy_n;
  assign others_req = |(~bus.req & gnt_for(owner_q));

  // Owner's release takes precedence over its own same-cycle reassertion.
  assign release_now = bus.req[owner_q]
                     | (started & others_req)
                     | (~started & ~busy & (cnt == CNT_LIM));

  // Rotating search starting just after the last served master; the last
  // served master is probed last, so it only wins when it is alone.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    probe      = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      probe = IDX_W'((int'(last) + i) % NUM_MASTERS);
      if (!cand_found && !bus.req[probe]) begin
        cand_found = 1'b1;
        cand       = probe;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt_q;
    owner_nx   = owner_q;
    vld_nx     = vld_q;
    last_nx    = last;
    started_nx = started;
    cnt_nx     = cnt;

    case (state)
      S_IDLE, S_DEAD: begin
        if (cand_found) begin
          if (state == S_IDLE && PARK_ON && vld_q && cand != PARK_IDX) begin
            // parked on someone else: revoke first so the handover has a gap
            state_nx = S_DEAD;
            gnt_nx   = '1;
            vld_nx   = 1'b0;
          end else begin
            state_nx   = S_GRANT;
            gnt_nx     = gnt_for(cand);
            owner_nx   = cand;
            vld_nx     = 1'b1;
            last_nx    = cand;
            started_nx = 1'b0;
            cnt_nx     = '0;
          end
        end else begin
          state_nx = S_IDLE;
          if (PARK_ON) begin
            gnt_nx   = gnt_for(PARK_IDX);
            owner_nx = PARK_IDX;
            vld_nx   = 1'b1;
          end else begin
            gnt_nx = '1;
            vld_nx = 1'b0;
          end
        end
      end

      S_GRANT: begin
        if (release_now) begin
          state_nx = S_DEAD;
          gnt_nx   = '1;
          vld_nx   = 1'b0;
        end else if (busy) begin
          started_nx = 1'b1;
        end else if (!started) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = S_IDLE;
        gnt_nx   = '1;
        vld_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      vld_q   <= 1'b0;
      last    <= LAST_RST;
      started <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      gnt_q   <= gnt_nx;
      owner_q <= owner_nx;
      vld_q   <= vld_nx;
      last    <= last_nx;
      started <= started_nx;
      cnt     <= cnt_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = vld_q;

endmodule

`default_nettype wire

// File: tb/tb_pci_rr_arbiter.sv
// ============================================================================
// tb_pci_rr_arbiter : scoreboard bench for pci_rr_arbiter (default build)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pci_rr_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  typedef struct {
    logic [N-1:0] gnt;
    logic         vld;
    logic [1:0]   owner;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference state: who holds the grant (-1 = nobody), rotation pointer,
  // transaction-started flag, idle cycles since grant, grant age
  int m_hold    = -1;
  int m_last    = N - 1;
  int m_owner   = 0;
  int m_cnt     = 0;
  int m_age     = 0;
  bit m_started = 1'b0;

  pci_rr_arbiter_if #(.NUM_MASTERS(N)) bus ();

  pci_rr_arbiter #(
    .NUM_MASTERS(N),
    .TIMEOUT    (TMO),
    .PARK_MASTER(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // next round-robin winner after m_last, or -1
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (r[j] == 1'b0) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic f, input logic i, input logic rs);
    bit busy;
    int others;
    int c;
    busy   = (f == 1'b0) || (i == 1'b0);
    others = 0;
    for (int k = 0; k < N; k++)
      if (k != m_hold && r[k] == 1'b0) others++;
    if (rs) begin
      m_hold = -1; m_last = N - 1; m_owner = 0; m_cnt = 0; m_started = 1'b0; m_age = 0;
    end else if (m_hold >= 0) begin
      if (r[m_hold] == 1'b1 || (m_started && others > 0) ||
          (!m_started && !busy && m_cnt == TMO - 1)) begin
        m_hold = -1;
      end else begin
        m_age++;
        if (busy) m_started = 1'b1;
        else if (!m_started) m_cnt++;
      end
    end else begin
      // a cycle with no grant is either the gap after a release or idle
      c = pick(r);
      if (c >= 0) begin
        m_hold = c; m_owner = c; m_last = c; m_started = 1'b0; m_cnt = 0; m_age = 0;
      end
    end
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic f, input logic i, input logic rs);
    exp_t e;
    bus.req     = r;
    bus.frame_n = f;
    bus.irdy_n  = i;
    rst         = rs;
    model_step(r, f, i, rs);
    e.gnt   = (m_hold < 0) ? {N{1'b1}} : ~(N'(1) << m_hold);
    e.vld   = (m_hold >= 0);
    e.owner = 2'(m_owner);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // monitor: compares DUT outputs after every edge that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("gnt", 32'(bus.gnt), 32'(e.gnt));
        check("owner_vld", 32'(bus.owner_vld), 32'(e.vld));
        check("owner", 32'(bus.owner), 32'(e.owner));
        check("gnt_onehot", 32'($countones(~bus.gnt) <= 1), 32'd1);
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic         f;
    logic         i;
    bus.req = '1; bus.frame_n = 1'b1; bus.irdy_n = 1'b1; rst = 1'b1;

    // reset with everyone requesting, then first grant to master 0
    repeat (3) cyc(4'b0000, 1'b1, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0);

    // all requesting; each owner drives FRAME# for its first cycles
    for (int k = 0; k < 30; k++) begin
      f = (m_hold >= 0 && m_age < 3) ? 1'b0 : 1'b1;
      cyc(4'b0000, f, 1'b1, 1'b0);
    end

    // sole requester master 2 never starts: timeout and re-grant
    repeat (45) cyc(4'b1011, 1'b1, 1'b1, 1'b0);

    // master 1 busy, master 3 joins mid-transaction
    repeat (4) cyc(4'b1101, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(4'b1101, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(4'b0101, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(4'b1111, 1'b1, 1'b1, 1'b0);

    // reset while master 2 owns a running transaction
    repeat (4) cyc(4'b1011, 1'b0, 1'b1, 1'b0);
    cyc(4'b1011, 1'b0, 1'b1, 1'b1);
    repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0);

    // randomized traffic with sticky request patterns and rare resets
    r = 4'b1111;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 5) == 0) r = N'($urandom);
      f = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
      i = ($urandom_range(0, 9) < 2) ? 1'b0 : 1'b1;
      if (k > 1000 && k < 1300) begin f = 1'b1; i = 1'b1; end
      cyc(r, f, i, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end
    cyc(4'b1111, 1'b1, 1'b1, 1'b0);

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
